toy_bpu_fetch_rob: RTL

//  In-order reorder buffer between icache fetch and the BPU filter.
//  - Holds DEPTH fetch slots; each is preallocated at icache request and completes when both
//    its icache ack (any order, tagged by id) and its bp2 verdict (in order) have arrived.
//  - Releases completed slots to the filter in allocation order via valid/ready.
//  - Silently drains slots killed by bp2 flush or frontend flush.

---
 rtl/toy_bpu_fetch_rob_pkg.sv | 18 +
 rtl/toy_bpu_rob_slot.sv | 42 ++++
 rtl/toy_bpu_fetch_rob.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/toy_bpu_fetch_rob_pkg.sv
// Shared types and sizing for the fetch reorder buffer between icache and the BPU filter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package toy_bpu_fetch_rob_pkg;

    localparam int FETCH_DATA_WIDTH = 32;
    localparam int BPU_ROB_DEPTH    = 8;
    localparam int BPU_ROB_ID_W     = $clog2(BPU_ROB_DEPTH);

    // Per-slot lifecycle flags; a slot is free when alloc is clear.
    typedef struct packed {
        logic alloc;
        logic acked;
        logic bp2_done;
        logic killed;
    } bpu_rob_slot_t;

endpackage

// File: rtl/toy_bpu_rob_slot.sv
// Flag state for one reorder-buffer slot: allocation, icache ack, bp2 verdict, kill.
// Latency: flags update one cycle after their set strobes.
// Backpressure: none; strobes are pre-qualified by the owning buffer.
module toy_bpu_rob_slot
    import toy_bpu_fetch_rob_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_set,
    input  logic          ack_set,
    input  logic          bp2_set,
    input  logic          bp2_kill,
    input  logic          flush_kill,
    input  logic          free_set,
    output bpu_rob_slot_t st
);

    // Allocation starts a clean lifecycle, release empties the slot, otherwise flags only accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= '0;
        end else if (alloc_set) begin
            st <= '{alloc: 1'b1, acked: 1'b0, bp2_done: 1'b0, killed: 1'b0};
        end else if (free_set) begin
            st <= '0;
        end else begin
            if (ack_set) begin
                st.acked <= 1'b1;
            end
            if (bp2_set) begin
                st.bp2_done <= 1'b1;
                if (bp2_kill) begin
                    st.killed <= 1'b1;
                end
            end
            if (flush_kill && st.alloc) begin
                st.killed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/toy_bpu_fetch_rob.sv
// In-order reorder buffer: slots allocated at icache request, completed by tagged ack plus in-order bp2 verdict.
// Latency: 1 cycle from last completion event to filter_vld; 0 cycles when the head ack bypasses (BYPASS_EN).
// Backpressure: head holds while filter_rdy is low; icache_prealloc_rdy drops when all DEPTH slots are occupied.
module toy_bpu_fetch_rob
    import toy_bpu_fetch_rob_pkg::*;
#(
    parameter int   DEPTH     = BPU_ROB_DEPTH,
    parameter int   DATA_W    = FETCH_DATA_WIDTH,
    parameter bit   BYPASS_EN = 1'b1,
    localparam int  ID_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_prealloc_vld,
    output logic              icache_prealloc_rdy,
    output logic [ID_W-1:0]   icache_prealloc_id,
    input  logic              icache_ack_vld,
    input  logic [ID_W-1:0]   icache_ack_id,
    input  logic [DATA_W-1:0] icache_ack_pld,
    input  logic              fe_ctrl_bp2_vld,
    input  logic              fe_ctrl_bp2_flush,
    input  logic              fe_ctrl_flush,
    output logic              filter_vld,
    input  logic              filter_rdy,
    output logic [DATA_W-1:0] filter_pld,
    output logic [ID_W:0]     rob_cnt,
    output logic              rob_empty
);

    localparam logic [ID_W-1:0] PTR_ONE  = ID_W'(1);
    localparam logic [ID_W:0]   CNT_ONE  = (ID_W+1)'(1);
    localparam logic [ID_W:0]   CNT_FULL = (ID_W+1)'(DEPTH);

    logic [ID_W-1:0]   alloc_ptr;
    logic [ID_W-1:0]   bp2_ptr;
    logic [ID_W-1:0]   head_ptr;
    logic [ID_W:0]     cnt;
    logic [DATA_W-1:0] pld [DEPTH];

    bpu_rob_slot_t     slot_st [DEPTH];
    bpu_rob_slot_t     head_st;

    logic              alloc_fire;
    logic              bp2_fire;
    logic              ack_head;
    logic              bypass_hit;
    logic              deliver_ok;
    logic              drain;
    logic              rel_fire;
    logic [DEPTH-1:0]  alloc_dec;
    logic [DEPTH-1:0]  ack_dec;
    logic [DEPTH-1:0]  bp2_dec;
    logic [DEPTH-1:0]  rel_dec;

    // Handshake qualification; flush wins over a same-cycle bp2 verdict.
    always_comb begin
        icache_prealloc_rdy = (cnt != CNT_FULL);
        alloc_fire          = icache_prealloc_vld && icache_prealloc_rdy;
        bp2_fire            = fe_ctrl_bp2_vld && !fe_ctrl_flush;
    end

    // Head decision: deliver when complete and live, drain when killed and no longer owed an ack.
    always_comb begin
        head_st    = slot_st[head_ptr];
        ack_head   = icache_ack_vld && (icache_ack_id == head_ptr);
        bypass_hit = BYPASS_EN && ack_head && !head_st.acked;
        deliver_ok = head_st.alloc && head_st.bp2_done && !head_st.killed &&
                     (head_st.acked || bypass_hit);
        filter_vld = deliver_ok && !fe_ctrl_flush;
        filter_pld = bypass_hit ? icache_ack_pld : pld[head_ptr];
        drain      = head_st.alloc && head_st.killed && head_st.acked;
        rel_fire   = (filter_vld && filter_rdy) || drain;
    end

    // Decode pointer/id strobes into per-slot set signals.
    always_comb begin
        alloc_dec = '0;
        ack_dec   = '0;
        bp2_dec   = '0;
        rel_dec   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_dec[i] = alloc_fire     && (alloc_ptr     == ID_W'(i));
            ack_dec[i]   = icache_ack_vld && (icache_ack_id == ID_W'(i));
            bp2_dec[i]   = bp2_fire       && (bp2_ptr       == ID_W'(i));
            rel_dec[i]   = rel_fire       && (head_ptr      == ID_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        toy_bpu_rob_slot u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .alloc_set  (alloc_dec[g]),
            .ack_set    (ack_dec[g]),
            .bp2_set    (bp2_dec[g]),
            .bp2_kill   (fe_ctrl_bp2_flush),
            .flush_kill (fe_ctrl_flush),
            .free_set   (rel_dec[g]),
            .st         (slot_st[g])
        );
    end

    // Pointers and occupancy; after a flush bp2 resumes at the first slot allocated from now on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            bp2_ptr   <= '0;
            head_ptr  <= '0;
            cnt       <= '0;
        end else begin
            if (alloc_fire) begin
                alloc_ptr <= alloc_ptr + PTR_ONE;
            end
            if (fe_ctrl_flush) begin
                bp2_ptr <= alloc_ptr;
            end else if (bp2_fire) begin
                bp2_ptr <= bp2_ptr + PTR_ONE;
            end
            if (rel_fire) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
            case ({alloc_fire, rel_fire})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Capture icache payload into its slot; ids are unique while a response is owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pld[i] <= '0;
            end
        end else if (icache_ack_vld) begin
            pld[icache_ack_id] <= icache_ack_pld;
        end
    end

    assign icache_prealloc_id = alloc_ptr;
    assign rob_cnt            = cnt;
    assign rob_empty          = (cnt == '0);

    a_ack_legal: assert property (@(posedge clk) disable iff (!rst_n)
        icache_ack_vld |-> (slot_st[icache_ack_id].alloc && !slot_st[icache_ack_id].acked));
    a_bp2_legal: assert property (@(posedge clk) disable iff (!rst_n)
        bp2_fire |-> ((bp2_ptr != alloc_ptr) || (cnt == CNT_FULL)));
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= CNT_FULL);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        rel_fire |-> (cnt != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (alloc_fire && !rel_fire) |-> (cnt != CNT_FULL));

endmodule
